// File: rtl/ipg_reply_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ipg_reply_fifo_if
// Brief    : Handshake/bus bundle between the IPG reply generator, the reply
//            FIFO and the 10G PHY TX encoder.
// Revision : 1.0
// ============================================================================
interface ipg_reply_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   level;
  logic [1:0]            tuser;
  logic                  overflow;

  modport master (
    output wr_data, wr_en, rd_req,
    input  rd_data, rd_valid, level, tuser, overflow
  );

  modport slave (
    input  wr_data, wr_en, rd_req,
    output rd_data, rd_valid, level, tuser, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ipg_reply_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ipg_reply_fifo
// Brief    : FWFT reply-chunk FIFO feeding the 10G TX encoder, with registered
//            back-pressure flags. Optional counters: IPG_REPLY_FIFO_STATS_EN.
// Revision : 1.0
// ============================================================================
module ipg_reply_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_LOG2  = 4,
  parameter int ALMOST_FULL = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ipg_reply_fifo_if.slave       fifo
`ifdef IPG_REPLY_FIFO_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           drop_count,
  output logic [31:0]           pop_count,
  output logic [DEPTH_LOG2:0]   max_level
`endif
);

  localparam int                  C_DEPTH = 1 << DEPTH_LOG2;
  localparam int                  C_LVL_W = DEPTH_LOG2 + 1;
  localparam logic [C_LVL_W-1:0]  c_depth_lvl = C_LVL_W'(C_DEPTH);
  localparam logic [C_LVL_W-1:0]  c_almost_full = C_LVL_W'(ALMOST_FULL);
  localparam logic [C_LVL_W-1:0]  c_lvl_one = C_LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_mem [0:C_DEPTH-1];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2-1:0]   w_rd_ptr_inc;
  logic [C_LVL_W-1:0]      r_level;
  logic [C_LVL_W-1:0]      w_level_next;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [DATA_WIDTH-1:0]   w_rd_data_next;
  logic [1:0]              r_tuser;
  logic                    r_overflow;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_wr_accept;
  logic                    w_drop;

  assign w_full       = (r_level == c_depth_lvl);
  assign w_pop        = fifo.rd_req & (r_state == ST_LOADED);
  assign w_wr_accept  = fifo.wr_en & (~w_full | w_pop);
  assign w_drop       = fifo.wr_en & w_full & ~w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + c_ptr_one;

  always_comb begin
    w_state_next   = r_state;
    w_rd_data_next = r_rd_data;
    w_level_next   = r_level;

    case ({w_wr_accept, w_pop})
      2'b10:   w_level_next = r_level + c_lvl_one;
      2'b01:   w_level_next = r_level - c_lvl_one;
      default: w_level_next = r_level;
    endcase

    case (r_state)
      ST_EMPTY: begin
        // A chunk written while empty becomes visible one edge later.
        if (r_level != '0) begin
          w_state_next   = ST_LOADED;
          w_rd_data_next = r_mem[r_rd_ptr];
        end
      end
      ST_LOADED: begin
        if (w_pop) begin
          if (r_level > c_lvl_one) begin
            w_rd_data_next = r_mem[w_rd_ptr_inc];
          end else if (w_wr_accept) begin
            // Last chunk leaves as a new one arrives: forward it directly.
            w_rd_data_next = fifo.wr_data;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_data <= w_rd_data_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tuser    <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_level    <= w_level_next;
      r_tuser    <= {(w_level_next == c_depth_lvl), (w_level_next >= c_almost_full)};
      r_overflow <= w_drop;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= fifo.wr_data;
    end
  end

  assign fifo.rd_data  = r_rd_data;
  assign fifo.rd_valid = (r_state == ST_LOADED);
  assign fifo.level    = r_level;
  assign fifo.tuser    = r_tuser;
  assign fifo.overflow = r_overflow;

`ifdef IPG_REPLY_FIFO_STATS_EN
  logic [15:0]        r_drop_count;
  logic [31:0]        r_pop_count;
  logic [C_LVL_W-1:0] r_max_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
      r_pop_count  <= '0;
      r_max_level  <= '0;
    end else if (stats_clr) begin
      r_drop_count <= '0;
      r_pop_count  <= '0;
      r_max_level  <= '0;
    end else begin
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_pop) begin
        r_pop_count <= r_pop_count + 32'd1;
      end
      if (w_level_next > r_max_level) begin
        r_max_level <= w_level_next;
      end
    end
  end

  assign drop_count = r_drop_count;
  assign pop_count  = r_pop_count;
  assign max_level  = r_max_level;
`else
  // Default build carries no statistics state.
`endif

endmodule
`default_nettype wire
